// File: rtl/pe_finish_barrier_if.sv
// Handshake bundle between the finish barrier, the PS start request and the PE array.
// The barrier connects through the master modport; the PS/PE side uses slave.
interface pe_finish_barrier_if #(
    parameter int unsigned NUM_PE     = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  go;
    logic [NUM_PE-1:0]     pe_done;
    logic                  pe_start;
    logic [NUM_PE-1:0]     finished;
    logic                  busy;
    logic                  all_done;
    logic [DATA_WIDTH-1:0] step_idx;
    logic                  timeout;

    modport master (
        input  go,
        input  pe_done,
        output pe_start,
        output finished,
        output busy,
        output all_done,
        output step_idx,
        output timeout
    );

    modport slave (
        output go,
        output pe_done,
        input  pe_start,
        input  finished,
        input  busy,
        input  all_done,
        input  step_idx,
        input  timeout
    );
endinterface

// File: rtl/pe_finish_barrier.sv
// Per-step launch/collect barrier for the diffusion step counter.
// Optional watchdog enabled by defining BARRIER_TIMEOUT_EN.
module pe_finish_barrier #(
    parameter int unsigned NUM_PE         = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_STEPS      = 7,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst,
    pe_finish_barrier_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [DATA_WIDTH:0] MAX_EXT = (DATA_WIDTH + 1)'(MAX_STEPS);
    localparam state_t START_STATE = (MAX_STEPS > 0) ? S_LAUNCH : S_DONE;

    state_t                state, state_next;
    logic [NUM_PE-1:0]     finished_q;
    logic [DATA_WIDTH-1:0] step_q;
    logic                  timeout_q;

    logic [NUM_PE-1:0]     merged;
    logic                  all_in;
    logic [DATA_WIDTH:0]   step_inc;
    logic                  last_step;
    logic                  wd_expire;

`ifdef BARRIER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    always_comb begin
        wd_expire = (32'(wd_cnt) + 32'd1) == TIMEOUT_CYCLES;
    end
`else
    always_comb begin
        wd_expire = 1'b0;
    end
`endif

    // step_idx + 1 is formed one bit wider so the limit compare cannot wrap
    always_comb begin
        merged    = finished_q | bus.pe_done;
        all_in    = &merged;
        step_inc  = {1'b0, step_q} + (DATA_WIDTH + 1)'(1);
        last_step = step_inc >= MAX_EXT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (bus.go) state_next = START_STATE;
            S_LAUNCH:  state_next = S_WAIT;
            S_WAIT: begin
                if (all_in)         state_next = S_RELEASE;
                else if (wd_expire) state_next = S_DONE;
            end
            S_RELEASE: state_next = last_step ? S_DONE : S_LAUNCH;
            S_DONE:    if (bus.go) state_next = START_STATE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            finished_q <= '0;
            step_q     <= '0;
            timeout_q  <= 1'b0;
`ifdef BARRIER_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_LAUNCH: begin
                    finished_q <= '0;
`ifdef BARRIER_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                end
                S_WAIT: begin
                    if (!all_in && wd_expire) begin
                        finished_q <= '0;
                        timeout_q  <= 1'b1;
                    end else begin
                        finished_q <= merged;
                    end
`ifdef BARRIER_TIMEOUT_EN
                    wd_cnt <= wd_cnt + WD_W'(1);
`endif
                end
                S_RELEASE: begin
                    finished_q <= '0;
                    step_q     <= step_inc[DATA_WIDTH-1:0];
                end
                S_DONE: begin
                    finished_q <= '0;
                    if (bus.go) begin
                        step_q    <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                default: finished_q <= '0;
            endcase
        end
    end

    assign bus.pe_start = (state == S_LAUNCH);
    assign bus.busy     = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_RELEASE);
    assign bus.all_done = (state == S_DONE);
    assign bus.finished = finished_q;
    assign bus.step_idx = step_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_pe_finish_barrier.sv
// Self-checking bench for pe_finish_barrier: step-level reference model compared every
// cycle, plus directed literal checks. Timeout scenario runs when BARRIER_TIMEOUT_EN is set.
module tb_pe_finish_barrier;

    localparam int NP   = 16;
    localparam int DW   = 32;
    localparam int MAXS = 7;
    localparam int TO   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    bit   cmp_en = 1'b0;

    pe_finish_barrier_if #(.NUM_PE(NP), .DATA_WIDTH(DW)) bus ();

    pe_finish_barrier #(
        .NUM_PE(NP),
        .DATA_WIDTH(DW),
        .MAX_STEPS(MAXS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: what each output must show during the cycle after an edge
    logic [NP-1:0] m_fin = '0;
    int            m_steps = 0;
    int            m_wait = 0;
    bit            m_launch = 0, m_collect = 0, m_release = 0, m_done = 0, m_to = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_fin = '0; m_steps = 0; m_wait = 0;
            m_launch = 0; m_collect = 0; m_release = 0; m_done = 0; m_to = 0;
        end else if (m_launch) begin
            m_launch = 0; m_collect = 1; m_fin = '0; m_wait = 0;
        end else if (m_collect) begin
            m_fin = m_fin | bus.pe_done;
            if (&m_fin) begin
                m_collect = 0; m_release = 1;
            end else begin
                m_wait++;
`ifdef BARRIER_TIMEOUT_EN
                if (m_wait == TO) begin
                    m_collect = 0; m_done = 1; m_to = 1; m_fin = '0;
                end
`endif
            end
        end else if (m_release) begin
            m_release = 0; m_fin = '0; m_steps++;
            if (m_steps < MAXS) m_launch = 1;
            else                m_done = 1;
        end else if (bus.go) begin
            m_steps = 0; m_to = 0; m_done = 0;
            if (MAXS > 0) m_launch = 1;
            else          m_done = 1;
        end
    end

    always @(negedge clk) begin
        if (bus.pe_start === 1'b1) start_cnt++;
        if (cmp_en) begin
            check("pe_start", 64'(bus.pe_start), 64'(m_launch));
            check("busy",     64'(bus.busy),     64'(m_launch | m_collect | m_release));
            check("all_done", 64'(bus.all_done), 64'(m_done));
            check("finished", 64'(bus.finished), 64'(m_fin));
            check("step_idx", 64'(bus.step_idx), 64'(m_steps));
            check("timeout",  64'(bus.timeout),  64'(m_to));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 50; i++) begin
            if (bus.pe_start === 1'b1) return;
            tick();
        end
        check("wait_pe_start", 64'(0), 64'(1));
    endtask

    task automatic wait_all_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.all_done === 1'b1) return;
            tick();
        end
        check("wait_all_done", 64'(0), 64'(1));
    endtask

    task automatic run_fast(input int n);
        for (int i = 0; i < n; i++) begin
            wait_start();
            tick();
            bus.pe_done = '1;
            tick();
            bus.pe_done = '0;
            tick();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pe_start"}, 64'(bus.pe_start), 64'(0));
        check({tag, "_busy"},     64'(bus.busy),     64'(0));
        check({tag, "_all_done"}, 64'(bus.all_done), 64'(0));
        check({tag, "_finished"}, 64'(bus.finished), 64'(0));
        check({tag, "_step_idx"}, 64'(bus.step_idx), 64'(0));
        check({tag, "_timeout"},  64'(bus.timeout),  64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global time limit");
    end

    initial begin
        int prev;
        bus.go = 1'b0;
        bus.pe_done = '0;
        rst = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rst0");

        // 1: fastest completion, 7 steps 3 cycles apart
        start_cnt = 0;
        prev = 0;
        pulse_go();
        check("t1_first_start", 64'(bus.pe_start), 64'(1));
        for (int i = 0; i < MAXS; i++) begin
            wait_start();
            if (i > 0) check("t1_start_gap", 64'(cyc - prev), 64'(3));
            prev = cyc;
            tick();
            bus.pe_done = '1;
            tick();
            bus.pe_done = '0;
            check("t1_release_vec", 64'(bus.finished), 64'(16'hFFFF));
            check("t1_step_hold", 64'(bus.step_idx), 64'(i));
            tick();
        end
        check("t1_start_count", 64'(start_cnt), 64'(7));
        check("t1_all_done", 64'(bus.all_done), 64'(1));
        check("t1_step_final", 64'(bus.step_idx), 64'(7));

        // 5: go in DONE restarts from step 0
        pulse_go();
        check("t5_all_done_low", 64'(bus.all_done), 64'(0));
        check("t5_step_zero", 64'(bus.step_idx), 64'(0));
        check("t5_start", 64'(bus.pe_start), 64'(1));

        // 2: staggered completion, PE15 ten cycles late
        tick();
        bus.pe_done = 16'h7FFF;
        tick();
        bus.pe_done = '0;
        for (int i = 0; i < 9; i++) begin
            check("t2_gap_vec", 64'(bus.finished), 64'(16'h7FFF));
            check("t2_gap_step", 64'(bus.step_idx), 64'(0));
            tick();
        end
        bus.pe_done = 16'h8000;
        tick();
        bus.pe_done = '0;
        check("t2_full_vec", 64'(bus.finished), 64'(16'hFFFF));
        check("t2_step_hold", 64'(bus.step_idx), 64'(0));
        tick();
        check("t2_step_inc", 64'(bus.step_idx), 64'(1));
        check("t2_restart", 64'(bus.pe_start), 64'(1));

        // 3: duplicate pulses from PE3 and go while waiting
        tick();
        bus.go = 1'b1;
        bus.pe_done = 16'h0008;
        tick();
        tick();
        bus.pe_done = 16'h0009;
        tick();
        bus.pe_done = '0;
        tick();
        check("t3_partial_vec", 64'(bus.finished), 64'(16'h0009));
        check("t3_busy", 64'(bus.busy), 64'(1));
        check("t3_no_restart", 64'(bus.pe_start), 64'(0));
        check("t3_step_hold", 64'(bus.step_idx), 64'(1));
        bus.go = 1'b0;
        bus.pe_done = 16'hFFF6;
        tick();
        bus.pe_done = '0;
        check("t3_full_vec", 64'(bus.finished), 64'(16'hFFFF));
        tick();
        check("t3_step_inc", 64'(bus.step_idx), 64'(2));
        run_fast(5);
        check("t3_all_done", 64'(bus.all_done), 64'(1));
        check("t3_step_final", 64'(bus.step_idx), 64'(7));

        // 4: reset during step 4 WAIT, then a clean full run
        pulse_go();
        run_fast(3);
        wait_start();
        tick();
        bus.pe_done = 16'h00FF;
        tick();
        bus.pe_done = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("t4_rst");
        pulse_go();
        run_fast(7);
        check("t4_all_done", 64'(bus.all_done), 64'(1));
        check("t4_step_final", 64'(bus.step_idx), 64'(7));

`ifdef BARRIER_TIMEOUT_EN
        // 6: PE7 never reports in step 2
        pulse_go();
        run_fast(1);
        wait_start();
        tick();
        bus.pe_done = 16'hFF7F;
        tick();
        bus.pe_done = '0;
        wait_all_done(40);
        check("t6_timeout", 64'(bus.timeout), 64'(1));
        check("t6_all_done", 64'(bus.all_done), 64'(1));
        check("t6_step", 64'(bus.step_idx), 64'(1));
        check("t6_finished", 64'(bus.finished), 64'(0));
        pulse_go();
        check("t6_timeout_clr", 64'(bus.timeout), 64'(0));
        check("t6_step_clr", 64'(bus.step_idx), 64'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_finish_barrier.md
# pe_finish_barrier

Upstream synchronisation barrier for the diffusion step counter. It launches all processing elements (PEs) for each diffusion step and collects their one-cycle completion pulses into sticky flags. When every PE has reported, it presents an all-ones `finished` vector for exactly one cycle, then relaunches the PEs, until `MAX_STEPS` steps are complete. Its `finished` bits drive the step counter's per-PE finished inputs directly; its `pe_start` fans out to the PE array.

## Interface
Parameters:
- `NUM_PE`, 16: number of PEs, equal to the width of `pe_done` and `finished`.
- `DATA_WIDTH`, 32: width of `step_idx`.
- `MAX_STEPS`, 7: number of steps to run. Must match the downstream counter's limit.
- `TIMEOUT_CYCLES`, 65535: watchdog limit in cycles spent in WAIT. Used only with `BARRIER_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: the single clock; all logic on its rising edge.
- `rst`, in, 1: reset, **synchronous, active-high**.
- `go`, in, 1: start request from the PS, level or pulse. Sampled only in IDLE and DONE.
- `pe_done`, in, `NUM_PE`: per-PE completion pulses, one cycle each.
- `pe_start`, out, 1: broadcast start pulse to all PEs.
- `finished`, out, `NUM_PE`: registered sticky completion flags.
- `busy`, out, 1: high in LAUNCH, WAIT and RELEASE.
- `all_done`, out, 1: high in DONE.
- `step_idx`, out, `DATA_WIDTH`: number of completed steps.
- `timeout`, out, 1: sticky watchdog flag. Tied to 0 when `BARRIER_TIMEOUT_EN` is not defined.

## Operation
- Registered FSM with five states:
  - **IDLE**: waits for `go`.
  - **LAUNCH**: issues the start pulse.
  - **WAIT**: collects completions.
  - **RELEASE**: presents the full `finished` vector.
  - **DONE**: run complete.
- All outputs are registered or decoded from state.
- **Reset**: state=IDLE; `finished`=0, `step_idx`=0, `pe_start`=0, `busy`=0, `all_done`=0, `timeout`=0. A reset asserted mid-run wins over every other event at that edge.
- **IDLE**:
  - `go`=1 with `MAX_STEPS`>0 → LAUNCH.
  - `go`=1 with `MAX_STEPS`=0 → DONE.
- **LAUNCH**:
  - `pe_start`=1 for this cycle only; `finished` cleared.
  - Next state is always WAIT.
  - `pe_done` is ignored in this cycle.
- **WAIT**:
  - Each edge sets `finished <= finished | pe_done`.
  - When `finished | pe_done` is all ones → RELEASE.
  - Repeated or simultaneous pulses from one PE are harmless.
- **RELEASE**:
  - `finished` is all ones for exactly this cycle; `pe_done` is ignored.
  - On exit: `step_idx <= step_idx + 1` and `finished <= 0`.
  - Next state is LAUNCH if `step_idx + 1 < MAX_STEPS`, else DONE.
- **DONE**:
  - `all_done`=1; `finished`=0; `step_idx` holds.
  - `go`=1 → clear `step_idx`, `all_done` and `timeout`, then proceed as from IDLE.
- `go` in LAUNCH, WAIT or RELEASE is ignored.
- `step_idx` never exceeds `MAX_STEPS` and never wraps.
- **Arithmetic**: `step_idx` is compared as unsigned against `MAX_STEPS` zero-extended to `DATA_WIDTH`.

## Timing
- `go` sampled at edge N → `pe_start`=1 during cycle N+1 (LAUNCH).
- The last missing `pe_done` sampled at edge M in WAIT → `finished`=all ones during cycle M+1.
- `step_idx` increments at edge M+2, together with `pe_start`=1 for the next step, or with `all_done`=1 after the final step.
- Minimum step period is 3 cycles (LAUNCH, WAIT, RELEASE), reached when all PEs pulse in the first WAIT cycle.
- Downstream counter: `finished` is all ones for exactly one cycle per step, so the counter increments exactly once per step.

## Configuration
- Macro: `BARRIER_TIMEOUT_EN`.
- **Defined**:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` before `finished` is complete → DONE, with `timeout`=1 and `all_done`=1.
  - `step_idx` holds the count of completed steps, and `finished` is cleared.
  - `timeout` stays high until `rst`, or `go` in DONE.
- **Not defined**: no counter; WAIT can last indefinitely; `timeout` is constant 0.

## Test plan
1. Reset, then `go` pulse with all 16 `pe_done` pulsed in the first WAIT cycle of every step → `pe_start` pulses 7 times, 3 cycles apart; `finished`=0xFFFF for one cycle per step; `step_idx` goes 0→7; `all_done`=1.
2. Staggered completion: PE0–PE14 pulse, PE15 pulses 10 cycles later → `finished`=0x7FFF during the gap; 0xFFFF appears one cycle after PE15's pulse; `step_idx` is unchanged until RELEASE exits.
3. Duplicate pulses from PE3, plus `go` asserted in WAIT → no early RELEASE, no restart, `step_idx` unaffected.
4. `rst` asserted during step 4 WAIT → the next cycle shows every output at its reset value; a new `go` runs all 7 steps from `step_idx`=0.
5. `go` in DONE → `all_done` falls, `step_idx`=0, and `pe_start` pulses one cycle later.
6. With `BARRIER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, PE7 never pulses in step 2 → `timeout`=1 and `all_done`=1 after 20 WAIT cycles; `step_idx`=1; `finished`=0.
